datapath_multicycle: RTL and testbench
======================================

Name: datapath_multicycle

Overview:
Parametrised multicycle successor of the 24-bit single-cycle datapath. It combines the datapath with its own control FSM, a 16-entry register file, and one shared memory port for instructions and data, using a req/ack handshake. Instruction encoding stays 24 bits; data and address width scale with WIDTH. It sits between the CPU top and a unified memory model or arbiter that may insert wait states.

Parameters:
WIDTH, 24, data/address/register width; must be at least 24 and a multiple of 8
PC_RESET, 10, PC value loaded on reset
IB, WIDTH/8, PC increment in bytes per instruction (local parameter, not overridable)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory transfer request
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  WIDTH  byte address
mem_wdata  out  WIDTH  store data
mem_rdata  in  WIDTH  load/fetch data; instruction is in bits [23:0]
mem_ack  in  1  transfer complete; may assert in the same cycle as mem_req
pc  out  WIDTH  current PC
opcode  out  4  IR[23:20], for debug and CU observation
halted  out  1  core stopped by HALT or TRAP
trap  out  1  illegal opcode or funct seen

Behaviour:
- Reset (async) values: pc=PC_RESET, IR=0, all registers=0, state=FETCH, mem_req=0, mem_we=0, halted=0, trap=0. mem_req drops immediately even mid-transfer; memory must tolerate an abandoned request.
- Instruction fields: op=[23:20], rs=[19:16], rt=[15:12], rd=[11:8], funct=[3:0], imm=[11:0] sign-extended to WIDTH.
- r0 reads 0; writes to r0 are discarded.
- Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata are held stable until a rising edge with mem_ack=1. mem_req deasserts the cycle after ack. mem_ack while mem_req=0 is ignored.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack: IR<=mem_rdata[23:0], go to DECODE.
- DECODE: A<=R[rs], B<=R[rt].
  - op=F: go to HALT.
  - Undefined op, or op=0 with funct>5: trap=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - op0 R-type, funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0). ALUOut<=A op B, go to WB.
  - op1 ADDI: ALUOut<=A+imm, go to WB.
  - op2 LW / op3 SW: ALUOut<=A+imm, go to MEM.
  - op4 BEQ / op5 BNE: taken if A==B (BEQ) or A!=B (BNE).
    - Taken: pc<=pc+IB+imm*IB. Not taken: pc<=pc+IB. Go to FETCH.
  - op6 JMP: pc<=imm*IB (sign-extended), go to FETCH.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=(op==3), mem_wdata=B. On ack:
  - SW: pc<=pc+IB, go to FETCH.
  - LW: MDR<=mem_rdata, go to WB.
- WB: R[rd]<=ALUOut (R-type); R[rt]<=ALUOut (ADDI); R[rt]<=MDR (LW). pc<=pc+IB, go to FETCH.
- HALT: halted=1, no memory requests, state held until Reset.
- Arithmetic and PC wrap modulo 2^WIDTH. No overflow trap.
- Latency with zero-wait memory: R/ADDI 4 cycles, LW 5, SW 4, branch/JMP 3. Each memory wait cycle adds 1.

Optional Feature:
PERF_CNT_EN.
- Defined: adds outputs cyc_cnt (WIDTH) and instret (WIDTH), both reset to 0.
  - cyc_cnt increments every cycle while halted=0.
  - instret increments when an instruction leaves WB, MEM (SW), or EXEC (branch/JMP).
  - Both wrap modulo 2^WIDTH.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Zero-wait memory, WIDTH=24, program at 10: 24'h101005 (ADDI r1,r0,5), 24'h102FFD (ADDI r2,r0,-3), 24'h012300 (ADD r3,r1,r2) -> r3=2 after 12 cycles; pc=19.
- SW r1 to address 40, then LW r4 from 40, with mem_ack delayed 3 cycles -> mem_addr/mem_wdata stable through the wait; r4=5; LW takes 5+3+3 cycles.
- BEQ with equal operands and imm=-1 -> pc returns to the branch's own address (pc+3-3); with unequal operands -> pc+3.
- Opcode 4'h9 fetched -> trap=1 and halted=1 after DECODE; mem_req stays 0 for all following cycles.
- Reset asserted mid-FETCH while waiting for ack -> mem_req=0 in the same cycle; pc=10 and registers=0 after release; execution restarts from 10.
- WIDTH=32 run of the same program -> pc steps by 4; ADDI sign-extends -3 to 32'hFFFFFFFD. With PERF_CNT_EN, instret=3 at the end.

Source files
------------

// File: rtl/datapath_multicycle.sv
// Multicycle datapath with its own control FSM, 16-entry register file and one shared
// req/ack memory port. Define PERF_CNT_EN to add the cyc_cnt_o/instret_o counters.
module datapath_multicycle #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned PC_RESET = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ack_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [3:0]       opcode_o,
  output logic             halted_o,
  output logic             trap_o
`ifdef PERF_CNT_EN
  ,
  output logic [WIDTH-1:0] cyc_cnt_o,
  output logic [WIDTH-1:0] instret_o
`endif
);

  localparam int unsigned IB = WIDTH / 8;
  localparam logic [WIDTH-1:0] IbW = WIDTH'(IB);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, alu_q, alu_d, a_q, b_q, mdr_q;
  logic [23:0]      ir_q;
  logic             trap_q;
  logic [WIDTH-1:0] regs_q [16];

  logic [3:0]       op, rs, rt, rd, funct;
  logic [WIDTH-1:0] imm_ext, imm_scaled;
  logic             illegal, rf_we;
  logic [3:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  assign op         = ir_q[23:20];
  assign rs         = ir_q[19:16];
  assign rt         = ir_q[15:12];
  assign rd         = ir_q[11:8];
  assign funct      = ir_q[3:0];
  assign imm_ext    = {{(WIDTH-12){ir_q[11]}}, ir_q[11:0]};
  assign imm_scaled = imm_ext * IbW;
  assign illegal    = (op >= 4'd7 && op <= 4'd14) || (op == 4'd0 && funct > 4'd5);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ack_i) state_d = StDecode;
      StDecode: state_d = (op == 4'hF || illegal) ? StHalt : StExec;
      StExec: begin
        case (op)
          4'd0, 4'd1: state_d = StWb;
          4'd2, 4'd3: state_d = StMem;
          default:    state_d = StFetch;
        endcase
      end
      StMem:    if (mem_ack_i) state_d = (op == 4'd3) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StHalt;
    endcase
  end

  // Reset gates the request combinationally so an in-flight transfer is abandoned at once.
  always_comb begin
    mem_req_o   = (state_q == StFetch || state_q == StMem) && !rst_i;
    mem_we_o    = (state_q == StMem) && (op == 4'd3);
    mem_addr_o  = (state_q == StMem) ? alu_q : pc_q;
    mem_wdata_o = b_q;
    halted_o    = (state_q == StHalt);
    trap_o      = trap_q;
    pc_o        = pc_q;
    opcode_o    = op;
  end

  always_comb begin
    alu_d = alu_q;
    pc_d  = pc_q;
    case (state_q)
      StExec: begin
        case (op)
          4'd0: begin
            case (funct)
              4'd0:    alu_d = a_q + b_q;
              4'd1:    alu_d = a_q - b_q;
              4'd2:    alu_d = a_q & b_q;
              4'd3:    alu_d = a_q | b_q;
              4'd4:    alu_d = a_q ^ b_q;
              default: alu_d = ($signed(a_q) < $signed(b_q)) ? WIDTH'(1) : '0;
            endcase
          end
          4'd1, 4'd2, 4'd3: alu_d = a_q + imm_ext;
          4'd4:    pc_d = (a_q == b_q) ? pc_q + IbW + imm_scaled : pc_q + IbW;
          4'd5:    pc_d = (a_q != b_q) ? pc_q + IbW + imm_scaled : pc_q + IbW;
          4'd6:    pc_d = imm_scaled;
          default: ;
        endcase
      end
      StMem:   if (mem_ack_i && op == 4'd3) pc_d = pc_q + IbW;
      StWb:    pc_d = pc_q + IbW;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= WIDTH'(PC_RESET);
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      mdr_q  <= '0;
      trap_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      alu_q <= alu_d;
      if (state_q == StFetch && mem_ack_i) ir_q <= mem_rdata_i[23:0];
      if (state_q == StDecode) begin
        a_q <= regs_q[rs];
        b_q <= regs_q[rt];
        if (illegal) trap_q <= 1'b1;
      end
      if (state_q == StMem && mem_ack_i) mdr_q <= mem_rdata_i;
    end
  end

  assign rf_we    = (state_q == StWb);
  assign rf_waddr = (op == 4'd0) ? rd : rt;
  assign rf_wdata = (op == 4'd2) ? mdr_q : alu_q;

  // r0 is never written, so it reads back as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (rf_we && rf_waddr != 4'd0) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

`ifdef PERF_CNT_EN
  logic [WIDTH-1:0] cyc_cnt_q, instret_q;
  logic             retire;

  assign retire = (state_q == StWb) ||
                  (state_q == StMem && mem_ack_i && op == 4'd3) ||
                  (state_q == StExec && op >= 4'd4 && op <= 4'd6);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_cnt_q <= '0;
      instret_q <= '0;
    end else begin
      if (!halted_o) cyc_cnt_q <= cyc_cnt_q + WIDTH'(1);
      if (retire)    instret_q <= instret_q + WIDTH'(1);
    end
  end

  assign cyc_cnt_o = cyc_cnt_q;
  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_datapath_multicycle.sv
// Bench for datapath_multicycle: ALU vector table, hand-written multi-cycle sequences and
// random programs compared against an instruction-level reference model.
module tb_datapath_multicycle;

  localparam int W = 24;
  localparam logic [W-1:0] IBW = 24'd3;
  localparam logic [23:0] HALT = 24'hF00000;

  logic         clk, rst, mem_req, mem_we, mem_ack, halted, trap;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]   opcode;
`ifdef PERF_CNT_EN
  logic [W-1:0] cyc_cnt, instret;
`endif

  logic [W-1:0] mem     [256];
  logic [W-1:0] ref_mem [256];
  int n_tests, n_fail, wait_cfg, stab_err;

  datapath_multicycle #(.WIDTH(24), .PC_RESET(10)) dut (
    .clk_i(clk), .rst_i(rst), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack), .pc_o(pc), .opcode_o(opcode), .halted_o(halted), .trap_o(trap)
`ifdef PERF_CNT_EN
    , .cyc_cnt_o(cyc_cnt), .instret_o(instret)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks after wait_cfg wait cycles, checks request stability while waiting.
  initial begin
    int cnt;
    logic pend, c_we;
    logic [W-1:0] c_addr, c_wdata;
    cnt = 0; pend = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (!pend) begin
          c_addr = mem_addr; c_we = mem_we; c_wdata = mem_wdata; pend = 1'b1;
        end else if (c_addr !== mem_addr || c_we !== mem_we || (c_we && c_wdata !== mem_wdata)) begin
          stab_err++;
        end
        if (cnt >= wait_cfg) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[7:0]];
          if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
          cnt = 0; pend = 1'b0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0; mem_rdata = '0; cnt = 0; pend = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] enc(input int op, input int rs, input int rt, input int lo);
    logic [3:0] o, s, t;
    logic [11:0] l;
    o = op[3:0]; s = rs[3:0]; t = rt[3:0]; l = lo[11:0];
    return {o, s, t, l};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = W'(HALT);
  endtask

  task automatic reset_release();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_halt(output int cyc);
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (halted) break;
      if (cyc > 5000) begin
        n_tests++; n_fail++;
        $display("FAIL halt_timeout: got running after %0d cycles expected halted", cyc);
        break;
      end
    end
  endtask

  task automatic wait_pc(input logic [W-1:0] target, input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (pc == target) break;
    end
    if (k == 200) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got pc %0h expected %0h", name, pc, target);
    end
  endtask

  // Instruction-level reference: executes ref_mem and tallies cycles from the latency table.
  task automatic ref_run(input int waits, output logic [W-1:0] fpc, output int cyc,
                         output logic ftrap, output int nret);
    logic [W-1:0] r [16];
    logic [W-1:0] p, imm, a, b, res, ea;
    logic [23:0] ins;
    int op, rs, rt, rd, fn;
    for (int i = 0; i < 16; i++) r[i] = '0;
    p = 24'd10; cyc = 0; ftrap = 1'b0; nret = 0;
    for (int k = 0; k < 2000; k++) begin
      ins = ref_mem[p[7:0]][23:0];
      op = int'(ins[23:20]); rs = int'(ins[19:16]); rt = int'(ins[15:12]);
      rd = int'(ins[11:8]); fn = int'(ins[3:0]);
      imm = {{(W-12){ins[11]}}, ins[11:0]};
      a = r[rs]; b = r[rt];
      cyc += 2 + waits;
      if (op == 15) break;
      if ((op >= 7 && op <= 14) || (op == 0 && fn > 5)) begin
        ftrap = 1'b1;
        break;
      end
      nret++;
      ea = a + imm;
      case (op)
        0: begin
          case (fn)
            0: res = a + b;
            1: res = a - b;
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            default: res = ($signed(a) < $signed(b)) ? 24'd1 : 24'd0;
          endcase
          if (rd != 0) r[rd] = res;
          cyc += 2; p += IBW;
        end
        1: begin if (rt != 0) r[rt] = ea; cyc += 2; p += IBW; end
        2: begin if (rt != 0) r[rt] = ref_mem[ea[7:0]]; cyc += 3 + waits; p += IBW; end
        3: begin ref_mem[ea[7:0]] = b; cyc += 2 + waits; p += IBW; end
        4: begin cyc += 1; p = (a == b) ? p + IBW * (imm + 24'd1) : p + IBW; end
        5: begin cyc += 1; p = (a != b) ? p + IBW * (imm + 24'd1) : p + IBW; end
        default: begin cyc += 1; p = imm * IBW; end
      endcase
    end
    fpc = p;
  endtask

  typedef struct {
    logic [3:0]  fn;
    logic [11:0] ia;
    logic [11:0] ib;
    logic [23:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int cyc, mcyc, nret, cnt, bad;
    logic [W-1:0] mpc;
    logic mtrap;
    logic [23:0] ins;

    vecs[0] = '{4'd0, 12'h005, 12'hFFD, 24'h000002};
    vecs[1] = '{4'd1, 12'h005, 12'hFFD, 24'h000008};
    vecs[2] = '{4'd2, 12'h0F0, 12'h0FF, 24'h0000F0};
    vecs[3] = '{4'd3, 12'h0F0, 12'h00F, 24'h0000FF};
    vecs[4] = '{4'd4, 12'h7FF, 12'h0F0, 24'h00070F};
    vecs[5] = '{4'd5, 12'hFFF, 12'h001, 24'h000001};
    vecs[6] = '{4'd5, 12'h001, 12'hFFF, 24'h000000};
    vecs[7] = '{4'd1, 12'h000, 12'h001, 24'hFFFFFF};
    vecs[8] = '{4'd0, 12'h800, 12'h800, 24'hFFF000};

    n_tests = 0; n_fail = 0; wait_cfg = 0; stab_err = 0;
    rst = 1'b1;
    fill_halt();
    #1;
    check("reset_pc", pc, 24'd10);
    check("reset_req", W'(mem_req), 24'd0);
    check("reset_halted", W'(halted), 24'd0);
    check("reset_trap", W'(trap), 24'd0);
    check("reset_opcode", W'(opcode), 24'd0);

    // Straight-line program: three ALU instructions in 12 cycles
    fill_halt();
    mem[10] = 24'h101005; mem[13] = 24'h102FFD; mem[16] = 24'h012300; mem[19] = 24'h3030C8;
    reset_release();
    step(12);
    check("prog1_pc_12cyc", pc, 24'd19);
    run_halt(cyc);
    check("prog1_r3", mem[200], 24'd2);

    // ALU vector table
    foreach (vecs[i]) begin
      fill_halt();
      mem[10] = enc(1, 0, 1, int'(vecs[i].ia));
      mem[13] = enc(1, 0, 2, int'(vecs[i].ib));
      mem[16] = enc(0, 1, 2, (3 << 8) | int'(vecs[i].fn));
      mem[19] = enc(3, 0, 3, 200);
      reset_release();
      run_halt(cyc);
      check($sformatf("alu_vec%0d", i), mem[200], vecs[i].exp);
      check($sformatf("alu_vec%0d_cycles", i), W'(cyc), 24'd18);
    end

    // Write to r0 is discarded
    fill_halt();
    mem[10] = 24'h101007; mem[13] = 24'h011000; mem[16] = 24'h3000C8;
    mem[200] = 24'h555555;
    reset_release();
    run_halt(cyc);
    check("r0_discard", mem[200], 24'd0);

    // SW then LW through a 3-cycle-wait memory
    wait_cfg = 3; stab_err = 0;
    fill_halt();
    mem[10] = 24'h101005; mem[13] = 24'h301028; mem[16] = 24'h204028; mem[19] = 24'h3040C8;
    reset_release();
    run_halt(cyc);
    check("lw_r4", mem[200], 24'd5);
    check("sw_mem40", mem[40], 24'd5);
    check("wait_cycles", W'(cyc), 24'd43);
    check("wait_stability", W'(stab_err), 24'd0);
    wait_cfg = 0;

    // Branches
    fill_halt();
    mem[10] = 24'h400FFF;
    reset_release();
    step(3);
    check("beq_self_pc", pc, 24'd10);
    check("beq_opcode", W'(opcode), 24'd4);
    step(3);
    check("beq_self_pc2", pc, 24'd10);
    fill_halt();
    mem[10] = 24'h101001; mem[13] = 24'h410FFF;
    reset_release();
    step(7);
    check("beq_ne_pc", pc, 24'd16);
    fill_halt();
    mem[10] = 24'h500FFF;
    reset_release();
    step(3);
    check("bne_eq_pc", pc, 24'd13);
    fill_halt();
    mem[10] = 24'h101001; mem[13] = 24'h510FFE;
    reset_release();
    step(7);
    check("bne_taken_pc", pc, 24'd10);

    // Jumps: negative imm wraps, positive imm scales by 3
    fill_halt();
    mem[10] = 24'h600FFF;
    reset_release();
    run_halt(cyc);
    check("jmp_neg_pc", pc, 24'hFFFFFD);
    check("jmp_cycles", W'(cyc), 24'd5);
    fill_halt();
    mem[10] = 24'h600014;
    reset_release();
    run_halt(cyc);
    check("jmp_pos_pc", pc, 24'd60);

    // Illegal opcode / funct and HALT
    fill_halt();
    mem[10] = 24'h900000;
    reset_release();
    step(2);
    check("trap_op9", W'(trap), 24'd1);
    check("trap_op9_halted", W'(halted), 24'd1);
    check("trap_op9_opcode", W'(opcode), 24'd9);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (mem_req) cnt++;
    end
    check("trap_no_req", W'(cnt), 24'd0);
    fill_halt();
    mem[10] = 24'h000006;
    reset_release();
    step(2);
    check("trap_funct6", W'(trap), 24'd1);
    fill_halt();
    reset_release();
    step(2);
    check("halt_halted", W'(halted), 24'd1);
    check("halt_no_trap", W'(trap), 24'd0);

    // Reset during a FETCH wait
    wait_cfg = 2;
    fill_halt();
    mem[10] = 24'h3010C8; mem[13] = 24'h101005; mem[16] = 24'h400FFD;
    reset_release();
    step(40);
    for (cnt = 0; cnt < 20; cnt++) begin
      if (mem_req && !mem_we) break;
      step(1);
    end
    check("rst_found_fetch", W'(mem_req && !mem_we), 24'd1);
    rst = 1'b1;
    #1;
    check("rst_req_drop", W'(mem_req), 24'd0);
    check("rst_pc", pc, 24'd10);
    mem[200] = 24'h123456;
    @(posedge clk);
    #2 rst = 1'b0;
    wait_pc(24'd13, "rst_restart");
    check("rst_regs_cleared", mem[200], 24'd0);
    wait_pc(24'd10, "rst_loop");
    wait_pc(24'd13, "rst_loop2");
    check("rst_r1_after", mem[200], 24'd5);

    // Random programs against the reference model
    for (int t = 0; t < 10; t++) begin
      wait_cfg = int'($urandom_range(0, 2));
      stab_err = 0;
      fill_halt();
      for (int i = 160; i <= 250; i++) mem[i] = W'($urandom());
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 5))
          0, 1: ins = enc(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'(($urandom_range(0, 15) << 8) | $urandom_range(0, 5)));
          2: ins = enc(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 4095)));
          3: ins = enc(2, 0, int'($urandom_range(0, 15)), int'($urandom_range(160, 250)));
          4: ins = enc(3, 0, int'($urandom_range(0, 15)), int'($urandom_range(160, 250)));
          default: ins = enc(int'($urandom_range(4, 5)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        endcase
        mem[10 + 3 * i] = W'(ins);
      end
      for (int j = 0; j < 15; j++) mem[10 + 3 * (20 + j)] = W'(enc(3, 0, j + 1, 130 + j));
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      reset_release();
      run_halt(cyc);
      ref_run(wait_cfg, mpc, mcyc, mtrap, nret);
      bad = 0;
      for (int i = 128; i <= 250; i++) if (mem[i] !== ref_mem[i]) bad++;
      check($sformatf("rand%0d_mem", t), W'(bad), 24'd0);
      check($sformatf("rand%0d_pc", t), pc, mpc);
      check($sformatf("rand%0d_cycles", t), W'(cyc), W'(mcyc));
      check($sformatf("rand%0d_trap", t), W'(trap), W'(mtrap));
      check($sformatf("rand%0d_stable", t), W'(stab_err), 24'd0);
`ifdef PERF_CNT_EN
      check($sformatf("rand%0d_instret", t), instret, W'(nret));
      check($sformatf("rand%0d_cyc_cnt", t), cyc_cnt, W'(mcyc));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
